// File: rtl/fm_hdmi_vtg.sv
// rtl/fm_hdmi_vtg.sv - HDMI video timing generator and YCbCr 4:2:2 pixel scheduler
module fm_hdmi_vtg #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic       clk_v,
    input  logic       rst,
    input  logic       i_enable,
    input  logic       i_clr_underflow,
    output logic       o_pix_req,
    input  logic       i_pix_valid,
    input  logic [7:0] i_pix_y,
    input  logic [7:0] i_pix_c,
    output logic [7:0] o_y,
    output logic [7:0] o_c,
    output logic       o_c_phase,
    output logic       o_de,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_frame_start,
    output logic       o_underflow
);

    localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
    localparam logic [11:0] H_HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST     = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] V_ACT      = 12'(V_ACTIVE);
    localparam logic [11:0] V_VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST     = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    localparam logic [7:0] Y_BLANK = 8'h10;
    localparam logic [7:0] C_BLANK = 8'h80;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [11:0] r_h_cnt;
    logic [11:0] r_v_cnt;
    logic        r_phase_acc;

    logic w_run;
    logic w_h_last;
    logic w_v_last;
    logic w_active;
    logic w_hs_win;
    logic w_vs_win;
    logic w_phase_cur;

    assign w_run    = (r_state == ST_RUN);
    assign w_h_last = (r_h_cnt == H_LAST);
    assign w_v_last = (r_v_cnt == V_LAST);
    assign w_active = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign w_hs_win = (r_h_cnt >= H_HS_START) && (r_h_cnt < H_HS_END);
    assign w_vs_win = (r_v_cnt >= V_VS_START) && (r_v_cnt < V_VS_END);

    // Chroma phase restarts at the start of every line; a line always begins with Cb.
    assign w_phase_cur = (r_h_cnt == 12'd0) ? 1'b0 : r_phase_acc;

    assign o_pix_req = w_run && w_active;

    // State register.
    always_ff @(posedge clk_v) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: enable is only looked at in IDLE and on the last pixel of a frame.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_enable) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_h_last && w_v_last && !i_enable) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Raster counters; held at zero outside RUN so a new frame always starts at the origin.
    always_ff @(posedge clk_v) begin
        if (rst || !w_run) begin
            r_h_cnt <= 12'd0;
            r_v_cnt <= 12'd0;
        end else if (w_h_last) begin
            r_h_cnt <= 12'd0;
            r_v_cnt <= w_v_last ? 12'd0 : r_v_cnt + 12'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 12'd1;
        end
    end

    // Chroma phase accumulator toggles once per popped pixel.
    always_ff @(posedge clk_v) begin
        if (rst) begin
            r_phase_acc <= 1'b0;
        end else if (o_pix_req) begin
            r_phase_acc <= ~w_phase_cur;
        end
    end

    // Output stage: one register between the counters/FIFO and the DDR output block.
    always_ff @(posedge clk_v) begin
        if (rst) begin
            o_de          <= 1'b0;
            o_y           <= Y_BLANK;
            o_c           <= C_BLANK;
            o_c_phase     <= 1'b0;
            o_hsync       <= ~HS_POL;
            o_vsync       <= ~VS_POL;
            o_frame_start <= 1'b0;
        end else begin
            o_de          <= o_pix_req;
            o_y           <= (o_pix_req && i_pix_valid) ? i_pix_y : Y_BLANK;
            o_c           <= (o_pix_req && i_pix_valid) ? i_pix_c : C_BLANK;
            o_c_phase     <= o_pix_req && w_phase_cur;
            o_hsync       <= (w_run && w_hs_win) ? HS_POL : ~HS_POL;
            o_vsync       <= (w_run && w_vs_win) ? VS_POL : ~VS_POL;
            o_frame_start <= w_run && (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
        end
    end

    // Sticky underflow flag; a new underflow beats a simultaneous clear.
    always_ff @(posedge clk_v) begin
        if (rst) begin
            o_underflow <= 1'b0;
        end else if (o_pix_req && !i_pix_valid) begin
            o_underflow <= 1'b1;
        end else if (i_clr_underflow) begin
            o_underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fm_hdmi_vtg.sv
// tb/tb_fm_hdmi_vtg.sv - self-checking bench for fm_hdmi_vtg on a 14x7 raster
module tb_fm_hdmi_vtg;

    localparam int HT = 14;
    localparam int FT = 98;

    logic       clk_v = 1'b0;
    logic       rst = 1'b1;
    logic       i_enable = 1'b0;
    logic       i_clr_underflow = 1'b0;
    logic       i_pix_valid = 1'b1;
    logic [7:0] i_pix_y = 8'h00;
    logic [7:0] i_pix_c = 8'h00;

    logic       o_pix_req, o_c_phase, o_de, o_hsync, o_vsync, o_frame_start, o_underflow;
    logic [7:0] o_y, o_c;
    logic       o2_pix_req, o2_c_phase, o2_de, o2_hsync, o2_vsync, o2_frame_start, o2_underflow;
    logic [7:0] o2_y, o2_c;

    fm_hdmi_vtg #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clk_v(clk_v), .rst(rst), .i_enable(i_enable), .i_clr_underflow(i_clr_underflow),
        .o_pix_req(o_pix_req), .i_pix_valid(i_pix_valid), .i_pix_y(i_pix_y), .i_pix_c(i_pix_c),
        .o_y(o_y), .o_c(o_c), .o_c_phase(o_c_phase), .o_de(o_de), .o_hsync(o_hsync),
        .o_vsync(o_vsync), .o_frame_start(o_frame_start), .o_underflow(o_underflow)
    );

    fm_hdmi_vtg #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_neg (
        .clk_v(clk_v), .rst(rst), .i_enable(i_enable), .i_clr_underflow(i_clr_underflow),
        .o_pix_req(o2_pix_req), .i_pix_valid(i_pix_valid), .i_pix_y(i_pix_y), .i_pix_c(i_pix_c),
        .o_y(o2_y), .o_c(o2_c), .o_c_phase(o2_c_phase), .o_de(o2_de), .o_hsync(o2_hsync),
        .o_vsync(o2_vsync), .o_frame_start(o2_frame_start), .o_underflow(o2_underflow)
    );

    always #5 clk_v = ~clk_v;

    typedef struct {
        logic [7:0] y;
        logic [7:0] c;
        logic       ph;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         k = -1;
    logic       exp_uf = 1'b0;
    logic       pend_uf = 1'b0;
    logic       en_wrap = 1'b0;
    int         uf_line = -1;
    int         uf_px = 0;
    logic [7:0] ramp = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic check_reset();
        chk("rst_de", o_de, 0);
        chk("rst_pix_req", o_pix_req, 0);
        chk("rst_hsync", o_hsync, 0);
        chk("rst_vsync", o_vsync, 0);
        chk("rst_y", o_y, 8'h10);
        chk("rst_c", o_c, 8'h80);
        chk("rst_c_phase", o_c_phase, 0);
        chk("rst_frame_start", o_frame_start, 0);
        chk("rst_underflow", o_underflow, 0);
        chk("rst_neg_hsync", o2_hsync, 1);
        chk("rst_neg_vsync", o2_vsync, 1);
    endtask

    // One pixel clock: sample on the falling edge, check everything, then feed the FIFO side.
    task automatic tick();
        logic en_c, clr_c, rst_c;
        int   kn, h, v;
        exp_t e;
        en_c  = i_enable;
        clr_c = i_clr_underflow;
        rst_c = rst;
        @(negedge clk_v);

        if (rst_c) exp_uf = 1'b0;
        else if (pend_uf) exp_uf = 1'b1;
        else if (clr_c) exp_uf = 1'b0;
        pend_uf = 1'b0;
        chk("underflow", o_underflow, exp_uf);

        chk("hs_polarity", o2_hsync ^ o_hsync, 1);
        chk("vs_polarity", o2_vsync ^ o_vsync, 1);

        if (o_de) begin
            if (sb.size() == 0) begin
                chk("sb_empty", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                chk("pix_y", o_y, e.y);
                chk("pix_c", o_c, e.c);
                chk("pix_phase", o_c_phase, e.ph);
            end
        end else begin
            chk("blank_y", o_y, 8'h10);
            chk("blank_c", o_c, 8'h80);
            chk("blank_phase", o_c_phase, 0);
        end

        if (k >= 0) k++;
        if (k < 0) begin
            if (o_frame_start) k = 0;
        end else if (k == FT) begin
            chk("fs_period", o_frame_start, en_wrap);
            if (o_frame_start) k = 0;
        end else begin
            chk("fs_none", o_frame_start, 0);
        end

        if (k >= 0 && k < FT) begin
            h = k % HT;
            v = k / HT;
            chk("raster_de", o_de, (h < 8) && (v < 4));
            chk("raster_hsync", o_hsync, (h >= 10) && (h < 12));
            chk("raster_vsync", o_vsync, v == 5);
            kn = k + 1;
            if (kn < FT) chk("pix_req", o_pix_req, ((kn % HT) < 8) && ((kn / HT) < 4));
            else         chk("pix_req_wrap", o_pix_req, en_c);
            if (k == FT - 1) en_wrap = en_c;
        end else if (k >= FT) begin
            chk("idle_de", o_de, 0);
            chk("idle_hsync", o_hsync, 0);
            chk("idle_vsync", o_vsync, 0);
            chk("idle_pix_req", o_pix_req, 0);
        end

        if (o_pix_req) begin
            kn = (k < 0) ? 0 : (k + 1) % FT;
            h = kn % HT;
            v = kn / HT;
            i_pix_y = ramp;
            i_pix_c = ramp ^ 8'h5A;
            ramp++;
            if (v == uf_line && h == uf_px) begin
                i_pix_valid = 1'b0;
                pend_uf = 1'b1;
                uf_line = -1;
            end else begin
                i_pix_valid = 1'b1;
            end
            e.y  = i_pix_valid ? i_pix_y : 8'h10;
            e.c  = i_pix_valid ? i_pix_c : 8'h80;
            e.ph = h[0];
            sb.push_back(e);
        end else begin
            i_pix_valid = 1'b1;
        end
    endtask

    task automatic wait_fs(input int lim);
        int n;
        n = 0;
        while (k != 0 && n < lim) begin
            tick();
            n++;
        end
        chk("fs_arrived", k, 0);
    endtask

    initial begin
        int n;

        // Reset and idle with enable low
        rst = 1'b1;
        repeat (3) tick();
        check_reset();
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_no_req", o_pix_req, 0);

        // Continuous run with a ramp; first frame then the wrap into frame two
        i_enable = 1'b1;
        wait_fs(20);
        repeat (97) tick();
        uf_line = 2;
        uf_px = 4;
        tick();
        chk("frame2_start", k, 0);

        // Underflow on line 2, hold, clear, then set-vs-clear collision on line 3
        repeat (40) tick();
        chk("uf_sticky", o_underflow, 1);
        i_clr_underflow = 1'b1;
        tick();
        i_clr_underflow = 1'b0;
        chk("uf_cleared", o_underflow, 0);
        uf_line = 3;
        uf_px = 2;
        i_clr_underflow = 1'b1;
        repeat (8) tick();
        i_clr_underflow = 1'b0;
        tick();

        // Reset in the middle of line 2, pixel 3 of the next frame
        n = 0;
        while (k != 30 && n < 300) begin
            tick();
            n++;
        end
        chk("reach_line2_px3", k, 30);
        rst = 1'b1;
        sb.delete();
        k = -1;
        tick();
        check_reset();
        rst = 1'b0;
        wait_fs(10);

        // Drop enable mid-frame: frame completes, then IDLE with no further frame_start
        repeat (50) tick();
        i_enable = 1'b0;
        repeat (100) tick();
        chk("stop_no_req", o_pix_req, 0);
        chk("stop_no_fs", o_frame_start, 0);
        repeat (30) tick();
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
